// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and sizing helpers.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold the value WIDTH itself, so it never wraps while counting bit positions.
    function automatic int counterWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder_structural.sv
// Gate-level 1-bit full adder cell shared across the lab designs.
module full_adder_structural (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic halfSum;
    logic genTerm;
    logic propTerm;

    xor gXor0 (halfSum, a_i, b_i);
    xor gXor1 (s_o, halfSum, c_i);
    and gAnd0 (genTerm, a_i, b_i);
    and gAnd1 (propTerm, halfSum, c_i);
    or  gOr0  (c_o, genTerm, propTerm);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: processes one bit per clock, LSB first, through a single full adder cell.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CW = counterWidth(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic             cellSum;
    logic             cellCarry;

    full_adder_structural uCell (
        .a_i (opA_q[0]),
        .b_i (opB_q[0]),
        .c_i (carry_q),
        .s_o (cellSum),
        .c_o (cellCarry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

    // Start is honoured only from IDLE or DONE; RUN ignores it so an addition cannot be reloaded.
    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        count_d = count_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    opA_d   = a;
                    opB_d   = b;
                    carry_d = c_in;
                    count_d = '0;
                end
            end
            RUN: begin
                opA_d   = {1'b0, opA_q[WIDTH-1:1]};
                opB_d   = {1'b0, opB_q[WIDTH-1:1]};
                sum_d   = {cellSum, sum_q[WIDTH-1:1]};
                carry_d = cellCarry;
                count_d = count_q + 1'b1;
                if (count_q == LAST_BIT) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The carry flop holds the final carry until the next accepted start, so it doubles as c_out.
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign c_out = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, multi-cycle corner sequences, random back-to-back run.
module tb_serial_adder;

    localparam int WIDTH = 8;
    localparam int TIMEOUT = 40;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;

    int assertCount;
    int failCount;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] expSum;
        logic             expCout;
    } vector_t;

    vector_t vectors [10];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Runs one isolated addition with a mid-RUN start and operand churn, then checks latency and result hold.
    task automatic applyStimulus(input vector_t v, input string tag);
        int cyc;
        int busyCycles;
        start = 1'b1;
        a     = v.a;
        b     = v.b;
        c_in  = v.cin;
        tick();
        start = 1'b0;
        a     = ~v.a;
        b     = v.b + 8'h11;
        c_in  = ~v.cin;
        cyc = 0;
        busyCycles = 0;
        while (!done && cyc < TIMEOUT) begin
            if (busy) busyCycles++;
            if (cyc == 3) begin
                start = 1'b1;
                a     = 8'h5C;
                b     = 8'hC3;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        checkOutput({tag, "_latency"}, 64'(cyc), 64'(WIDTH));
        checkOutput({tag, "_busyCycles"}, 64'(busyCycles), 64'(WIDTH));
        checkOutput({tag, "_sum"}, 64'(sum), 64'(v.expSum));
        checkOutput({tag, "_cout"}, 64'(c_out), 64'(v.expCout));
        tick();
        checkOutput({tag, "_donePulse"}, 64'(done), 64'(0));
        checkOutput({tag, "_busyAfter"}, 64'(busy), 64'(0));
        checkOutput({tag, "_sumHold"}, 64'({c_out, sum}), 64'({v.expCout, v.expSum}));
    endtask

    initial begin
        int cyc;
        int doneSeen;
        int lastDone;
        logic [WIDTH:0] expTotal;
        logic [WIDTH-1:0] ra, rb;
        logic rc;

        assertCount = 0;
        failCount   = 0;

        vectors[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vectors[1] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vectors[2] = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0};
        vectors[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vectors[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vectors[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vectors[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vectors[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vectors[8] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vectors[9] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        #3;
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_sum", 64'(sum), 64'(0));
        checkOutput("reset_cout", 64'(c_out), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("idle_busy", 64'(busy), 64'(0));

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i], $sformatf("vec%0d", i));
        end

        // Held start: back-to-back additions with a done pulse every WIDTH+1 cycles.
        start = 1'b1;
        a     = 8'h03;
        b     = 8'h04;
        c_in  = 1'b0;
        tick();
        cyc = 0;
        doneSeen = 0;
        lastDone = 0;
        while (doneSeen < 3 && cyc < 4 * TIMEOUT) begin
            tick();
            cyc++;
            if (done) begin
                checkOutput($sformatf("held_sum%0d", doneSeen), 64'({c_out, sum}), 64'(9'h007));
                if (doneSeen == 0) begin
                    checkOutput("held_firstDone", 64'(cyc), 64'(WIDTH));
                end else begin
                    checkOutput($sformatf("held_spacing%0d", doneSeen), 64'(cyc - lastDone), 64'(WIDTH + 1));
                end
                lastDone = cyc;
                doneSeen++;
            end
        end
        checkOutput("held_doneCount", 64'(doneSeen), 64'(3));
        start = 1'b0;
        for (int i = 0; i < WIDTH + 2; i++) tick();
        checkOutput("held_idle", 64'({busy, done}), 64'(0));

        // Asynchronous reset three cycles into RUN aborts with no done pulse.
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        c_in  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("abort_preBusy", 64'(busy), 64'(1));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_done", 64'(done), 64'(0));
        checkOutput("abort_sum", 64'(sum), 64'(0));
        checkOutput("abort_cout", 64'(c_out), 64'(0));
        tick();
        rst = 1'b0;
        doneSeen = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            tick();
            if (done || busy) doneSeen++;
        end
        checkOutput("abort_noDone", 64'(doneSeen), 64'(0));
        applyStimulus(vectors[7], "postReset");

        // Random back-to-back transactions, each start issued during the previous done cycle.
        ra = 8'($urandom);
        rb = 8'($urandom);
        rc = 1'($urandom);
        expTotal = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
        start = 1'b1;
        a     = ra;
        b     = rb;
        c_in  = rc;
        tick();
        for (int t = 0; t < 1000; t++) begin
            start = 1'b0;
            a     = 8'($urandom);
            b     = 8'($urandom);
            c_in  = 1'($urandom);
            cyc = 0;
            while (!done && cyc < TIMEOUT) begin
                tick();
                cyc++;
            end
            if (cyc >= TIMEOUT) begin
                checkOutput("rand_timeout", 64'(0), 64'(1));
                break;
            end
            checkOutput($sformatf("rand%0d", t), 64'({c_out, sum}), 64'(expTotal));
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            expTotal = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            start = (t < 999);
            a     = ra;
            b     = rb;
            c_in  = rc;
            tick();
        end
        start = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition, sampled on the rising edge of clk.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each: operands, sampled only on the edge where start is accepted.
REQ-006 The block SHALL have port c_in, input, 1 bit: carry-in, sampled with a and b.
REQ-007 The block SHALL have port busy, output, 1 bit: addition in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking sum and c_out valid.
REQ-009 The block SHALL have port sum, output, WIDTH bits: registered result.
REQ-010 The block SHALL have port c_out, output, 1 bit: registered carry-out.

Function
REQ-011 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 IDLE SHALL go to RUN on start=1; otherwise it SHALL stay in IDLE.
REQ-013 RUN SHALL go to DONE after exactly WIDTH cycles.
REQ-014 DONE SHALL go to RUN on start=1; otherwise it SHALL go to IDLE.
REQ-015 On accepting start, the block SHALL load a and b into operand shift registers, load c_in into the carry flop, and clear the bit counter.
REQ-016 Each RUN cycle SHALL add one bit position, LSB first:
- inputs: operand LSBs plus the carry flop;
- the sum bit enters the result register at the MSB and shifts right;
- the carry flop takes the cell carry;
- the operand registers shift right;
- the counter increments.
REQ-017 Latency: with start accepted at edge E0, busy SHALL be 1 from E0 until E_WIDTH, and done SHALL be 1 for the single cycle after E_WIDTH.
REQ-018 busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-019 Arithmetic: {c_out,sum} SHALL equal a + b + c_in, computed modulo 2^(WIDTH+1).
REQ-020 sum and c_out SHALL be valid when done=1 and SHALL hold until the next accepted start; their values during RUN are unspecified.
REQ-021 start while busy=1 SHALL be ignored: no reload, and no effect on the current result.
REQ-022 start during the done cycle SHALL be accepted, giving back-to-back operation with no idle gap.
REQ-023 Operand changes on a, b or c_in outside the accepting edge SHALL have no effect.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never wrap during RUN.

Reset
REQ-025 While rst=1, the block SHALL force the following asynchronously, independent of clk:
- state=IDLE;
- busy=0, done=0;
- sum=0, c_out=0;
- counter, carry flop and operand registers all 0.
REQ-026 Reset asserted mid-RUN SHALL abort the addition with no done pulse.
REQ-027 After reset deasserts, the first start SHALL behave as from power-up.

Structure
REQ-028 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL be defined as constants in a shared package serial_adder_pkg.
REQ-029 The per-bit addition SHALL use exactly one instance of the team's 1-bit full adder cell (full_adder_structural); the FSM, shift registers, counter and carry flop SHALL be coded in serial_adder.

Verification
REQ-030 WIDTH=8, a=8'hFF, b=8'h01, c_in=0, start pulsed -> done pulses 8 cycles after the start edge; sum=8'h00, c_out=1.
REQ-031 a=8'hA5, b=8'h5A, c_in=1 -> sum=8'h00, c_out=1; busy high for exactly 8 cycles.
REQ-032 start held high continuously with a=8'h03, b=8'h04, c_in=0 -> repeated results sum=8'h07, c_out=0; done pulses every 9 cycles; mid-RUN start is ignored.
REQ-033 rst asserted 3 cycles into RUN -> busy, done, sum and c_out all 0 immediately; no done pulse follows.
REQ-034 Random back-to-back operands (1000 transactions) -> every done matches a+b+c_in against the reference model.
